// File: rtl/jesd204b_rx_comma_ctrl.sv
// JESD204B single-lane RX link controller: K28.5 comma alignment, CGS, LMFC tracking and nSYNC.
// Optional macro SYSREF_RELOCK_EN: every accepted SYSREF realigns LMFC (default: only the first one).
module jesd204b_rx_comma_ctrl #(
    parameter int DIV_DCLK   = 4,
    parameter int FRAME_SIZE = 1,
    parameter int FMLC_NUM   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [19:0] i_rx_data,
    input  logic        i_sysref,
    output logic        o_nsync,
    output logic [19:0] o_data,
    output logic        o_data_valid,
    output logic [4:0]  o_comma_offset,
    output logic        o_lmfc_tick,
    output logic        o_sysref_seen
);
    localparam int LMFC_WORDS = FRAME_SIZE * FMLC_NUM / 2;
    localparam int LW = (LMFC_WORDS > 1) ? $clog2(LMFC_WORDS) : 1;
    localparam int SW = $clog2(DIV_DCLK + 1);
    localparam logic [9:0] K_RDN = 10'h17C;
    localparam logic [9:0] K_RDP = 10'h283;

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_WAIT = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == K_RDN) || (sym == K_RDP);
    endfunction

    logic [19:0]   prev_q;
    logic [39:0]   win_s;
    logic          found_s;
    logic [4:0]    found_off_s;
    logic [4:0]    offset_q, offset_d;
    logic [19:0]   data_q, data_d;
    logic [1:0]    kcnt_q, kcnt_d;
    logic [1:0]    mis_q, mis_d;
    state_t        state_q, state_d;
    logic [SW-1:0] sr_cnt_q, sr_cnt_d;
    logic          accept_s, relock_s;
    logic [LW-1:0] lmfc_q, lmfc_d;
    logic          tick_q, seen_q, nsync_q;

    assign win_s = {i_rx_data, prev_q};

    // Lowest bit offset holding a comma of either disparity
    always_comb begin
        found_s     = 1'b0;
        found_off_s = 5'd0;
        for (int k = 19; k >= 0; k--) begin
            if (is_comma(win_s[k +: 10])) begin
                found_s     = 1'b1;
                found_off_s = 5'(k);
            end
        end
    end

    // Alignment, CGS run length and SYSREF filter next-state
    always_comb begin
        data_d = win_s[offset_q +: 20];
        if (state_q == ST_CGS && found_s) begin
            offset_d = found_off_s;
        end else begin
            offset_d = offset_q;
        end
        if (is_comma(data_d[9:0]) && is_comma(data_d[19:10])) begin
            kcnt_d = (kcnt_q == 2'd3) ? 2'd3 : kcnt_q + 2'd1;
        end else begin
            kcnt_d = 2'd0;
        end
        // Counter saturates at DIV_DCLK so a long pulse is accepted only once
        if (!i_sysref) begin
            sr_cnt_d = '0;
        end else if (sr_cnt_q != SW'(DIV_DCLK)) begin
            sr_cnt_d = sr_cnt_q + 1'b1;
        end else begin
            sr_cnt_d = sr_cnt_q;
        end
        accept_s = i_sysref && (sr_cnt_q == SW'(DIV_DCLK - 1));
    end

    // LMFC counter next-state; SYSREF realignment overrides the natural wrap
    always_comb begin
`ifdef SYSREF_RELOCK_EN
        relock_s = accept_s;
`else
        relock_s = accept_s && !seen_q;
`endif
        if (relock_s) begin
            lmfc_d = '0;
        end else if (lmfc_q == LW'(LMFC_WORDS - 1)) begin
            lmfc_d = '0;
        end else begin
            lmfc_d = lmfc_q + 1'b1;
        end
    end

    // Link FSM next-state and comma miscount
    always_comb begin
        state_d = state_q;
        mis_d   = 2'd0;
        case (state_q)
            ST_CGS: begin
                if (kcnt_q >= 2'd2) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_CGS;
                end
            end
            ST_WAIT: begin
                if (kcnt_q == 2'd0) begin
                    state_d = ST_CGS;
                end else if (tick_q && seen_q) begin
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SYNC: begin
                if (found_s && (found_off_s != offset_q)) begin
                    if (mis_q == 2'd3) begin
                        state_d = ST_CGS;
                    end else begin
                        mis_d = mis_q + 2'd1;
                    end
                end else begin
                    mis_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_CGS;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q   <= 20'd0;
            offset_q <= 5'd0;
            data_q   <= 20'd0;
            kcnt_q   <= 2'd0;
            mis_q    <= 2'd0;
            state_q  <= ST_CGS;
            sr_cnt_q <= '0;
            lmfc_q   <= '0;
            tick_q   <= 1'b0;
            seen_q   <= 1'b0;
            nsync_q  <= 1'b0;
        end else begin
            prev_q   <= i_rx_data;
            offset_q <= offset_d;
            data_q   <= data_d;
            kcnt_q   <= kcnt_d;
            mis_q    <= mis_d;
            state_q  <= state_d;
            sr_cnt_q <= sr_cnt_d;
            lmfc_q   <= lmfc_d;
            tick_q   <= (lmfc_d == '0);
            seen_q   <= seen_q | accept_s;
            nsync_q  <= (state_d == ST_SYNC);
        end
    end

    assign o_nsync        = nsync_q;
    assign o_data_valid   = nsync_q;
    assign o_data         = data_q;
    assign o_comma_offset = offset_q;
    assign o_lmfc_tick    = tick_q;
    assign o_sysref_seen  = seen_q;
endmodule

// File: tb/tb_jesd204b_rx_comma_ctrl.sv
// Bench for jesd204b_rx_comma_ctrl: every-cycle comparison against a behavioural link model,
// plus directed scenarios with hand-computed literal expectations.
module tb_jesd204b_rx_comma_ctrl;
    localparam int DIV_DCLK   = 4;
    localparam int LMFC_WORDS = 4;
    localparam logic [9:0] K_RDN = 10'h17C;
    localparam logic [9:0] K_RDP = 10'h283;
    localparam logic [19:0] K_PAIR = 20'h5F283;
`ifdef SYSREF_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [19:0] i_rx_data = 20'd0;
    logic        i_sysref = 1'b0;
    logic        o_nsync, o_data_valid, o_lmfc_tick, o_sysref_seen;
    logic [19:0] o_data;
    logic [4:0]  o_comma_offset;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sr_lo1 = -1, sr_hi1 = -1, sr_lo2 = -1, sr_hi2 = -1;
    logic bq[$];

    jesd204b_rx_comma_ctrl dut (
        .i_clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_sysref(i_sysref),
        .o_nsync(o_nsync), .o_data(o_data), .o_data_valid(o_data_valid),
        .o_comma_offset(o_comma_offset), .o_lmfc_tick(o_lmfc_tick), .o_sysref_seen(o_sysref_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_k(input logic [9:0] s);
        return (s == K_RDN) || (s == K_RDP);
    endfunction

    // Behavioural model: history-based view of the link rules
    int m_state, m_off, m_run, m_mis, m_highs, m_cyc, m_anchor;
    logic [19:0] m_prev, m_data;
    logic m_nsync, m_tick, m_seen;
    bit m_ready = 1'b0;

    task automatic model_advance();
        logic [39:0] win;
        logic [19:0] nd;
        int k, nxt;
        bit acc;
        if (i_rst) begin
            m_state = 0; m_off = 0; m_run = 0; m_mis = 0; m_highs = 0;
            m_cyc = 0; m_anchor = 0; m_prev = 20'd0; m_data = 20'd0;
            m_nsync = 1'b0; m_tick = 1'b0; m_seen = 1'b0; m_ready = 1'b1;
        end else begin
            win = {i_rx_data, m_prev};
            k = -1;
            for (int j = 19; j >= 0; j--) begin
                if (is_k(10'(win >> j))) k = j;
            end
            acc = i_sysref && (m_highs + 1 == DIV_DCLK);
            m_highs = i_sysref ? m_highs + 1 : 0;
            nxt = m_state;
            case (m_state)
                0: if (m_run >= 2) nxt = 1;
                1: begin
                    if (m_run == 0) nxt = 0;
                    else if (m_tick && m_seen) nxt = 2;
                end
                default: begin
                    if (k >= 0 && k != m_off) m_mis++;
                    else m_mis = 0;
                    if (m_mis == 4) nxt = 0;
                end
            endcase
            if (nxt != 2) m_mis = 0;
            nd = 20'(win >> m_off);
            if (m_state == 0 && k >= 0) m_off = k;
            m_data = nd;
            m_run = (is_k(nd[9:0]) && is_k(nd[19:10])) ? m_run + 1 : 0;
            if (acc && (RELOCK || !m_seen)) m_anchor = m_cyc + 1;
            if (acc) m_seen = 1'b1;
            m_cyc++;
            m_tick = (((m_cyc - m_anchor) % LMFC_WORDS) == 0);
            m_state = nxt;
            m_nsync = (nxt == 2);
            m_prev = i_rx_data;
        end
    endtask

    always @(negedge clk) begin
        if (m_ready) begin
            check("m_nsync",  32'(o_nsync),        32'(m_nsync));
            check("m_valid",  32'(o_data_valid),   32'(m_nsync));
            check("m_data",   32'(o_data),         32'(m_data));
            check("m_offset", 32'(o_comma_offset), 32'(m_off));
            check("m_tick",   32'(o_lmfc_tick),    32'(m_tick));
            check("m_seen",   32'(o_sysref_seen),  32'(m_seen));
        end
        model_advance();
    end

    task automatic push_sym(input logic [9:0] s);
        for (int b = 0; b < 10; b++) bq.push_back(s[b]);
    endtask

    task automatic drive_cycle();
        logic [19:0] w;
        @(posedge clk); #1;
        while (bq.size() < 20) begin
            push_sym(K_RDP);
            push_sym(K_RDN);
        end
        for (int b = 0; b < 20; b++) w[b] = bq.pop_front();
        i_rst = 1'b0;
        i_rx_data = w;
        i_sysref = (cyc >= sr_lo1 && cyc <= sr_hi1) || (cyc >= sr_lo2 && cyc <= sr_hi2);
        cyc++;
    endtask

    // Drive through cycle c, then sample that cycle on the falling edge
    task automatic go_to(input int c);
        while (cyc <= c) drive_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset(input int pad);
        @(posedge clk); #1;
        i_rst = 1'b1; i_sysref = 1'b0; i_rx_data = 20'd0;
        @(posedge clk); #1;
        bq.delete();
        repeat (pad) bq.push_back(1'b0);
        cyc = 0;
        sr_lo1 = -1; sr_hi1 = -1; sr_lo2 = -1; sr_hi2 = -1;
    endtask

    initial begin
        int n;
        // Reset state, then comma stream at offset 0 without SYSREF
        do_reset(0);
        go_to(0);
        check("rst_nsync",  32'(o_nsync), 32'd0);
        check("rst_data",   32'(o_data), 32'd0);
        check("rst_valid",  32'(o_data_valid), 32'd0);
        check("rst_offset", 32'(o_comma_offset), 32'd0);
        check("rst_tick",   32'(o_lmfc_tick), 32'd0);
        check("rst_seen",   32'(o_sysref_seen), 32'd0);
        go_to(40);
        check("s1_offset", 32'(o_comma_offset), 32'd0);
        check("s1_data",   32'(o_data), 32'(K_PAIR));
        check("s1_nsync",  32'(o_nsync), 32'd0);
        check("s1_valid",  32'(o_data_valid), 32'd0);

        // Stream delayed by 7 bits
        do_reset(7);
        go_to(30);
        check("s2_offset", 32'(o_comma_offset), 32'd7);
        check("s2_data",   32'(o_data), 32'(K_PAIR));
        check("s2_nsync",  32'(o_nsync), 32'd0);

        // Short SYSREF pulse is ignored; LMFC keeps its reset phase
        do_reset(0);
        sr_lo1 = 2; sr_hi1 = 4;
        go_to(6);
        check("s4_tick6", 32'(o_lmfc_tick), 32'd0);
        go_to(8);
        check("s4_tick8", 32'(o_lmfc_tick), 32'd1);
        check("s4_seen",  32'(o_sysref_seen), 32'd0);
        go_to(12);
        check("s4_tick12", 32'(o_lmfc_tick), 32'd1);

        // SYSREF high 5 cycles: accept on 4th, tick next, nSYNC one cycle later
        do_reset(0);
        sr_lo1 = 6; sr_hi1 = 10;
        go_to(9);
        check("s3_seen9",  32'(o_sysref_seen), 32'd0);
        check("s3_tick9",  32'(o_lmfc_tick), 32'd0);
        go_to(10);
        check("s3_tick10", 32'(o_lmfc_tick), 32'd1);
        check("s3_seen10", 32'(o_sysref_seen), 32'd1);
        check("s3_nsync10", 32'(o_nsync), 32'd0);
        go_to(11);
        check("s3_nsync11", 32'(o_nsync), 32'd1);
        check("s3_valid11", 32'(o_data_valid), 32'd1);

        // Stream slips 3 bits while synced: fall back to CGS and relock at offset 3
        go_to(14);
        repeat (3) bq.push_back(1'b0);
        n = 0;
        while (o_nsync !== 1'b0 && n < 30) begin
            go_to(cyc);
            n++;
        end
        check("s5_fall", 32'(o_nsync), 32'd0);
        go_to(cyc + 15);
        check("s5_offset", 32'(o_comma_offset), 32'd3);
        check("s5_data",   32'(o_data), 32'(K_PAIR));
        n = 0;
        while (o_nsync !== 1'b1 && n < 30) begin
            go_to(cyc);
            n++;
        end
        check("s5_resync", 32'(o_nsync), 32'd1);

        // Second SYSREF lands mid-multiframe
        do_reset(0);
        sr_lo1 = 2; sr_hi1 = 5;
        sr_lo2 = 11; sr_hi2 = 14;
        go_to(6);
        check("s6_tick6", 32'(o_lmfc_tick), 32'd1);
        check("s6_seen6", 32'(o_sysref_seen), 32'd1);
        go_to(15);
        check("s6_tick15", 32'(o_lmfc_tick), RELOCK ? 32'd1 : 32'd0);
        go_to(18);
        check("s6_tick18", 32'(o_lmfc_tick), RELOCK ? 32'd0 : 32'd1);
        go_to(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
